// File: rtl/axi_slave_mem_if.sv
// AXI bus bundle between the DMA master port and the slave memory model.
interface axi_slave_mem_if #(
    parameter int ID_BITS   = 4,
    parameter int LEN_BITS  = 4,
    parameter int SIZE_BITS = 3
);
    logic [ID_BITS-1:0]   awid;
    logic [31:0]          awaddr;
    logic [LEN_BITS-1:0]  awlen;
    logic [SIZE_BITS-1:0] awsize;
    logic                 awvalid;
    logic                 awready;

    logic [ID_BITS-1:0]   wid;
    logic [63:0]          wdata;
    logic [7:0]           wstrb;
    logic                 wlast;
    logic                 wvalid;
    logic                 wready;

    logic [ID_BITS-1:0]   bid;
    logic [1:0]           bresp;
    logic                 bvalid;
    logic                 bready;

    logic [ID_BITS-1:0]   arid;
    logic [31:0]          araddr;
    logic [LEN_BITS-1:0]  arlen;
    logic [SIZE_BITS-1:0] arsize;
    logic                 arvalid;
    logic                 arready;

    logic [ID_BITS-1:0]   rid;
    logic [63:0]          rdata;
    logic [1:0]           rresp;
    logic                 rlast;
    logic                 rvalid;
    logic                 rready;

    modport master (
        output awid, awaddr, awlen, awsize, awvalid, input awready,
        output wid, wdata, wstrb, wlast, wvalid, input wready,
        input bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arvalid, input arready,
        input rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input awid, awaddr, awlen, awsize, awvalid, output awready,
        input wid, wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input arid, araddr, arlen, arsize, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );
endinterface

// File: rtl/axi_slave_mem.sv
// AXI slave memory: 64-bit INCR bursts, one outstanding burst per channel,
// independent write (AW/W/B) and read (AR/R) state machines.
module axi_slave_mem #(
    parameter int ID_BITS   = 4,
    parameter int LEN_BITS  = 4,
    parameter int SIZE_BITS = 3,
    parameter int MEM_DEPTH = 1024
) (
    input  logic           clk,
    input  logic           reset,
    axi_slave_mem_if.slave bus
);
    localparam int IDX_BITS = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA} rstate_t;

    function automatic logic in_range(input logic [31:0] a);
        return (a >> 3) < 32'(MEM_DEPTH);
    endfunction

    function automatic logic size_ok(input logic [SIZE_BITS-1:0] s);
        return 32'(s) < 32'd4;
    endfunction

    function automatic logic [31:0] stride(input logic [SIZE_BITS-1:0] s);
        return 32'd1 << s;
    endfunction

    logic [63:0] mem [MEM_DEPTH];

    wstate_t              wstate;
    logic [ID_BITS-1:0]   wid_q;
    logic [31:0]          waddr_q;
    logic [LEN_BITS-1:0]  wlen_q;
    logic [SIZE_BITS-1:0] wsize_q;
    logic [LEN_BITS-1:0]  wbeat_q;
    logic                 werr_q;

    rstate_t              rstate;
    logic [31:0]          raddr_q;
    logic [LEN_BITS-1:0]  rlen_q;
    logic [SIZE_BITS-1:0] rsize_q;
    logic [LEN_BITS-1:0]  rbeat_q;
    logic [LEN_BITS-1:0]  rbeat_nxt;

    logic                 w_fire;
    logic                 w_last_beat;
    logic                 w_ok;
    logic                 w_we;
    logic                 w_bad;
    logic [IDX_BITS-1:0]  w_idx;

    logic [31:0]          r_addr;
    logic [SIZE_BITS-1:0] r_size;
    logic                 r_ok;
    logic [IDX_BITS-1:0]  r_idx;
    logic [63:0]          rd_word;
    logic [1:0]           rd_resp;

    // Write beat qualification: address range, id match and wlast placement
    always_comb begin
        w_fire      = bus.wvalid && bus.wready;
        w_last_beat = (wbeat_q == wlen_q);
        w_ok        = in_range(waddr_q) && size_ok(wsize_q);
        w_we        = w_fire && w_ok;
        w_idx       = waddr_q[3 +: IDX_BITS];
        w_bad       = !w_ok || (bus.wid != wid_q) || (bus.wlast != w_last_beat);
    end

    // Byte-strobed memory write; contents survive reset
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int unsigned b = 0; b < 8; b++) begin
                if (bus.wstrb[b]) mem[w_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
            end
        end
    end

    // Word for the next read beat; a write landing on the same edge is merged
    // in so the newly registered beat already reflects it
    always_comb begin
        r_addr    = (rstate == R_IDLE) ? bus.araddr : raddr_q;
        r_size    = (rstate == R_IDLE) ? bus.arsize : rsize_q;
        r_ok      = in_range(r_addr);
        r_idx     = r_addr[3 +: IDX_BITS];
        rbeat_nxt = rbeat_q + 1'b1;
        rd_resp   = (!r_ok || !size_ok(r_size)) ? 2'b10 : 2'b00;
        rd_word   = '0;
        if (r_ok) begin
            rd_word = mem[r_idx];
            if (w_we && (w_idx == r_idx)) begin
                for (int unsigned b = 0; b < 8; b++) begin
                    if (bus.wstrb[b]) rd_word[8*b +: 8] = bus.wdata[8*b +: 8];
                end
            end
        end
    end

    // Write channel FSM: address accept, data beats, response hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wstate      <= W_IDLE;
            bus.awready <= 1'b0;
            bus.wready  <= 1'b0;
            bus.bvalid  <= 1'b0;
            bus.bid     <= '0;
            bus.bresp   <= '0;
            wid_q       <= '0;
            waddr_q     <= '0;
            wlen_q      <= '0;
            wsize_q     <= '0;
            wbeat_q     <= '0;
            werr_q      <= 1'b0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (bus.awvalid && bus.awready) begin
                        wid_q       <= bus.awid;
                        waddr_q     <= bus.awaddr;
                        wlen_q      <= bus.awlen;
                        wsize_q     <= bus.awsize;
                        wbeat_q     <= '0;
                        werr_q      <= 1'b0;
                        bus.awready <= 1'b0;
                        bus.wready  <= 1'b1;
                        wstate      <= W_DATA;
                    end else begin
                        bus.awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        waddr_q <= waddr_q + stride(wsize_q);
                        wbeat_q <= wbeat_q + 1'b1;
                        werr_q  <= werr_q | w_bad;
                        if (w_last_beat) begin
                            bus.wready <= 1'b0;
                            bus.bvalid <= 1'b1;
                            bus.bid    <= wid_q;
                            bus.bresp  <= (werr_q || w_bad) ? 2'b10 : 2'b00;
                            wstate     <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bus.bready) begin
                        bus.bvalid  <= 1'b0;
                        bus.bid     <= '0;
                        bus.bresp   <= '0;
                        bus.awready <= 1'b1;
                        wstate      <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Read channel FSM: address accept, back-to-back beats until rlast handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rstate      <= R_IDLE;
            bus.arready <= 1'b0;
            bus.rvalid  <= 1'b0;
            bus.rid     <= '0;
            bus.rdata   <= '0;
            bus.rresp   <= '0;
            bus.rlast   <= 1'b0;
            raddr_q     <= '0;
            rlen_q      <= '0;
            rsize_q     <= '0;
            rbeat_q     <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (bus.arvalid && bus.arready) begin
                        rlen_q      <= bus.arlen;
                        rsize_q     <= bus.arsize;
                        rbeat_q     <= '0;
                        raddr_q     <= bus.araddr + stride(bus.arsize);
                        bus.arready <= 1'b0;
                        bus.rvalid  <= 1'b1;
                        bus.rid     <= bus.arid;
                        bus.rdata   <= rd_word;
                        bus.rresp   <= rd_resp;
                        bus.rlast   <= (bus.arlen == '0);
                        rstate      <= R_DATA;
                    end else begin
                        bus.arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (bus.rvalid && bus.rready) begin
                        if (bus.rlast) begin
                            bus.rvalid  <= 1'b0;
                            bus.rid     <= '0;
                            bus.rdata   <= '0;
                            bus.rresp   <= '0;
                            bus.rlast   <= 1'b0;
                            bus.arready <= 1'b1;
                            rstate      <= R_IDLE;
                        end else begin
                            rbeat_q   <= rbeat_nxt;
                            raddr_q   <= raddr_q + stride(rsize_q);
                            bus.rdata <= rd_word;
                            bus.rresp <= rd_resp;
                            bus.rlast <= (rbeat_nxt == rlen_q);
                        end
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end
endmodule

// File: doc/axi_slave_mem.md
Name: axi_slave_mem

Overview:
- AXI slave memory model in synthesizable RTL. It is the downstream stage of the DMA controller's AXI master port and services its read and write bursts.
- 64-bit data path. Independent read and write channels, one outstanding burst per channel.
- The UVM AXI monitor observes it in block and system benches.

Parameters:
- ID_BITS, 4, width of awid/wid/bid/arid/rid
- LEN_BITS, 4, burst length field; beats = len+1
- SIZE_BITS, 3, burst size field; bytes per beat = 1<<size, legal 0..3
- MEM_DEPTH, 1024, number of 64-bit words; power of 2

Ports:
- clk in 1 clock
- reset in 1 async active-high reset
- awid/awaddr/awlen/awsize in ID_BITS/32/LEN_BITS/SIZE_BITS write address
- awvalid in 1; awready out 1
- wid in ID_BITS; wdata in 64; wstrb in 8; wlast in 1; wvalid in 1; wready out 1
- bid out ID_BITS; bresp out 2; bvalid out 1; bready in 1
- arid/araddr/arlen/arsize in ID_BITS/32/LEN_BITS/SIZE_BITS read address
- arvalid in 1; arready out 1
- rid out ID_BITS; rdata out 64; rresp out 2; rlast out 1; rvalid out 1; rready in 1

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (ports clk, reset).
- Reset: all outputs 0. Both FSMs go to IDLE. Memory contents are not cleared. Reset mid-burst aborts the burst immediately; no response is issued.
- Handshake: transfer on a rising edge with valid&&ready. Outputs are registered. Once asserted, bvalid/rvalid and their payloads stay stable until the handshake.
- Addressing: INCR bursts only. Beat n address = start + n*(1<<size), 32-bit wrap. Word index = addr>>3. A beat is in range iff addr>>3 < MEM_DEPTH.
- Size > 3: whole burst is treated as error.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. AW handshake latches id/addr/len/size, clears the beat count and error flag, and moves to W_DATA. awready drops next cycle.
  - W_DATA: wready=1. Each W handshake writes the bytes with wstrb=1 into the word, if the beat is in range.
  - Error flag is set by: out-of-range beat, wid != latched id, or wlast asserted on a beat other than beat len. Out-of-range beats are dropped.
  - On beat len: move to W_RESP (wready drops next cycle). wlast low on that beat also sets the error flag.
  - W_RESP: bvalid=1, bid=latched id, bresp=2'b10 if error flag else 2'b00. On bready move to W_IDLE; awready=1 next cycle.
- Read FSM R_IDLE -> R_DATA:
  - R_IDLE: arready=1. AR handshake latches fields and moves to R_DATA; rvalid=1 with beat 0 in the next cycle.
  - R_DATA: rdata = full word at current index, or 0 if out of range. rresp = 2'b10 if out of range or size illegal, else 2'b00. rid = latched id. rlast=1 only on beat len.
  - Each R handshake presents the next beat in the following cycle; rvalid stays high (no bubbles).
  - After the rlast handshake: rvalid=0 and return to R_IDLE; arready=1 the following cycle.
- Simultaneous write and read of the same word: a write committed on edge k is visible to any beat presented after edge k. A beat already registered before edge k is unchanged.
- Both channels run fully concurrently; neither has priority.
- Minimum turnaround: 1 idle cycle between bursts on each channel.

Test Plan:
- Single write, awaddr=0x10, len=0, wdata=0x1122334455667788, wstrb=0xFF; then read same address -> bresp=00 one cycle after W handshake; rdata=0x1122334455667788, rlast=1, rresp=00.
- Write len=3 at 0x100 with wstrb=0x0F on beat 2; bready held low 5 cycles -> bvalid/bid held stable for 5 cycles; read back shows beat 2 upper 4 bytes unchanged.
- Read len=7 at 0x40 with rready toggling 1,0,1,0 -> 8 beats in address order, no beat lost or duplicated, rlast only on beat 8.
- Write at MEM_DEPTH*8-8, len=1 -> beat 0 stored, beat 1 dropped, bresp=10; read of the same burst -> rresp 00 then 10, second rdata=0.
- wid != awid, and separately wlast asserted on beat 0 of a len=2 burst -> bresp=10 in both cases, burst still completes after 3 beats.
- reset pulsed during W_DATA beat 1 and R_DATA beat 2 -> all outputs 0 during reset, awready/arready=1 after release, no B or R response for the aborted bursts.
